ultimate_game_controller: RTL

- Sequences all rule logic for ultimate tic-tac-toe: 9 sub-boards of 9 cells each, giving 81 cells.
- Accepts cursor-generated move requests over a valid/ready handshake and checks legality.
- Writes the cell, then runs a time-multiplexed win scan, one line per cycle, over the sub-board and then the meta-board.
- Drives turn, active-board, game-over and score state consumed by the board renderer and the 7-seg score display.

---
 rtl/ultimate_game_controller.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ultimate_game_controller.sv
// Rule sequencer for ultimate tic-tac-toe: checks move legality, writes the cell,
// then scans one line per cycle over the sub-board and, on a sub-board win, the meta-board.
//
// state     | meaning
// IDLE      | waiting for a move request; ready while the game is not over
// LEGAL     | latched move checked against the board state
// SCAN_SUB  | eight lines of the target sub-board, one per cycle
// SCAN_META | eight lines of the meta-board, one per cycle
// UPDATE    | ack, turn toggle, next forced board, game-over and score
module ultimate_game_controller #(
   parameter int SCORE_W = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               i_new_game,
   input  logic               i_move_valid,
   output logic               o_move_ready,
   input  logic [3:0]         i_board,
   input  logic [3:0]         i_cell,
   output logic               o_move_ack,
   output logic               o_move_reject,
   output logic               o_turn,
   output logic [3:0]         o_active_board,
   output logic [80:0]        o_cell_used,
   output logic [80:0]        o_cell_sign,
   output logic [8:0]         o_board_won,
   output logic [8:0]         o_board_winner,
   output logic [8:0]         o_board_full,
   output logic               o_game_over,
   output logic [1:0]         o_winner,
   output logic [SCORE_W-1:0] o_score_x,
   output logic [SCORE_W-1:0] o_score_o
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_LEGAL     = 3'd1;
   localparam logic [2:0] S_SCAN_SUB  = 3'd2;
   localparam logic [2:0] S_SCAN_META = 3'd3;
   localparam logic [2:0] S_UPDATE    = 3'd4;

   logic [2:0]         r_state;
   logic [3:0]         r_board;
   logic [3:0]         r_cell;
   logic               r_mover;
   logic [2:0]         r_line;
   logic               r_hit;
   logic               r_metahit;
   logic               r_ack;
   logic               r_reject;
   logic               r_turn;
   logic [3:0]         r_active;
   logic [80:0]        r_used;
   logic [80:0]        r_sign;
   logic [8:0]         r_won;
   logic [8:0]         r_winner;
   logic [8:0]         r_full;
   logic               r_over;
   logic [1:0]         r_winner_code;
   logic [SCORE_W-1:0] r_score_x;
   logic [SCORE_W-1:0] r_score_o;

   logic               w_ready;
   logic [8:0]         w_sub_used;
   logic [8:0]         w_sub_sign;
   logic [11:0]        w_line;
   logic [3:0]         w_la;
   logic [3:0]         w_lb;
   logic [3:0]         w_lc;
   logic               w_sub_line_hit;
   logic               w_meta_line_hit;
   logic               w_sub_hit_final;
   logic [8:0]         w_bmask;
   logic [8:0]         w_cmask;
   logic [6:0]         w_idx;
   logic               w_illegal;
   logic               w_dest_blocked;

   // Three cell indices of line l inside a 3x3 grid: rows, columns, diagonals.
   function automatic logic [11:0] f_line(input logic [2:0] l);
      case (l)
         3'd0:    f_line = {4'd0, 4'd1, 4'd2};
         3'd1:    f_line = {4'd3, 4'd4, 4'd5};
         3'd2:    f_line = {4'd6, 4'd7, 4'd8};
         3'd3:    f_line = {4'd0, 4'd3, 4'd6};
         3'd4:    f_line = {4'd1, 4'd4, 4'd7};
         3'd5:    f_line = {4'd2, 4'd5, 4'd8};
         3'd6:    f_line = {4'd0, 4'd4, 4'd8};
         default: f_line = {4'd2, 4'd4, 4'd6};
      endcase
   endfunction

   always_comb begin
      w_sub_used = '0;
      w_sub_sign = '0;
      for (int b = 0; b < 9; b++) begin
         if (r_board == 4'(b)) begin
            w_sub_used = r_used[b*9 +: 9];
            w_sub_sign = r_sign[b*9 +: 9];
         end
      end
   end

   assign w_ready  = (r_state == S_IDLE) && !r_over;
   assign w_line   = f_line(r_line);
   assign w_la     = w_line[11:8];
   assign w_lb     = w_line[7:4];
   assign w_lc     = w_line[3:0];
   // Shift masks keep out-of-range board/cell numbers from indexing past the vectors.
   assign w_bmask  = 9'd1 << r_board;
   assign w_cmask  = 9'd1 << r_cell;
   assign w_idx    = 7'(r_board) * 7'd9 + 7'(r_cell);

   assign w_sub_line_hit = w_sub_used[w_la] && w_sub_used[w_lb] && w_sub_used[w_lc] &&
                           (w_sub_sign[w_la] == r_mover) && (w_sub_sign[w_lb] == r_mover) &&
                           (w_sub_sign[w_lc] == r_mover);
   assign w_meta_line_hit = r_won[w_la] && r_won[w_lb] && r_won[w_lc] &&
                            (r_winner[w_la] == r_mover) && (r_winner[w_lb] == r_mover) &&
                            (r_winner[w_lc] == r_mover);
   assign w_sub_hit_final = r_hit || w_sub_line_hit;

   assign w_illegal = (r_board > 4'd8) || (r_cell > 4'd8) ||
                      ((r_active != 4'd9) && (r_board != r_active)) ||
                      (|(r_won & w_bmask)) || (|(r_full & w_bmask)) ||
                      (|(w_sub_used & w_cmask));
   assign w_dest_blocked = |((r_won | r_full) & w_cmask);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_board       <= '0;
         r_cell        <= '0;
         r_mover       <= 1'b0;
         r_line        <= '0;
         r_hit         <= 1'b0;
         r_metahit     <= 1'b0;
         r_ack         <= 1'b0;
         r_reject      <= 1'b0;
         r_turn        <= 1'b0;
         r_active      <= 4'd9;
         r_used        <= '0;
         r_sign        <= '0;
         r_won         <= '0;
         r_winner      <= '0;
         r_full        <= '0;
         r_over        <= 1'b0;
         r_winner_code <= 2'b00;
         r_score_x     <= '0;
         r_score_o     <= '0;
      end else if (i_new_game) begin
         r_state       <= S_IDLE;
         r_line        <= '0;
         r_hit         <= 1'b0;
         r_metahit     <= 1'b0;
         r_ack         <= 1'b0;
         r_reject      <= 1'b0;
         r_turn        <= 1'b0;
         r_active      <= 4'd9;
         r_used        <= '0;
         r_sign        <= '0;
         r_won         <= '0;
         r_winner      <= '0;
         r_full        <= '0;
         r_over        <= 1'b0;
         r_winner_code <= 2'b00;
      end else begin
         r_ack    <= 1'b0;
         r_reject <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_move_valid && w_ready) begin
                  r_board <= i_board;
                  r_cell  <= i_cell;
                  r_mover <= r_turn;
                  r_state <= S_LEGAL;
               end
            end
            S_LEGAL: begin
               if (w_illegal) begin
                  r_reject <= 1'b1;
                  r_state  <= S_IDLE;
               end else begin
                  r_used[w_idx] <= 1'b1;
                  r_sign[w_idx] <= r_mover;
                  r_line        <= '0;
                  r_hit         <= 1'b0;
                  r_metahit     <= 1'b0;
                  r_state       <= S_SCAN_SUB;
               end
            end
            S_SCAN_SUB: begin
               r_hit  <= w_sub_hit_final;
               r_line <= r_line + 3'd1;
               if (r_line == 3'd7) begin
                  r_won    <= w_sub_hit_final ? (r_won | w_bmask) : (r_won & ~w_bmask);
                  r_winner <= r_mover ? (r_winner | w_bmask) : (r_winner & ~w_bmask);
                  r_full   <= (&w_sub_used) ? (r_full | w_bmask) : (r_full & ~w_bmask);
                  r_state  <= w_sub_hit_final ? S_SCAN_META : S_UPDATE;
               end
            end
            S_SCAN_META: begin
               r_metahit <= r_metahit || w_meta_line_hit;
               r_line    <= r_line + 3'd1;
               if (r_line == 3'd7)
                  r_state <= S_UPDATE;
            end
            S_UPDATE: begin
               r_ack    <= 1'b1;
               r_turn   <= ~r_turn;
               r_active <= w_dest_blocked ? 4'd9 : r_cell;
               if (r_metahit) begin
                  r_over        <= 1'b1;
                  r_winner_code <= r_mover ? 2'b10 : 2'b01;
                  if (r_mover) begin
                     if (!(&r_score_o))
                        r_score_o <= r_score_o + {{(SCORE_W-1){1'b0}}, 1'b1};
                  end else begin
                     if (!(&r_score_x))
                        r_score_x <= r_score_x + {{(SCORE_W-1){1'b0}}, 1'b1};
                  end
               end else if (&(r_won | r_full)) begin
                  r_over        <= 1'b1;
                  r_winner_code <= 2'b11;
               end
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_move_ready   = w_ready;
   assign o_move_ack     = r_ack;
   assign o_move_reject  = r_reject;
   assign o_turn         = r_turn;
   assign o_active_board = r_active;
   assign o_cell_used    = r_used;
   assign o_cell_sign    = r_sign;
   assign o_board_won    = r_won;
   assign o_board_winner = r_winner;
   assign o_board_full   = r_full;
   assign o_game_over    = r_over;
   assign o_winner       = r_winner_code;
   assign o_score_x      = r_score_x;
   assign o_score_o      = r_score_o;

endmodule
